// File: rtl/pipe_reg.sv
// pipe_reg: elastic register pipeline with valid/ready handshake, bubble collapse and synchronous flush.
module pipe_reg #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         CLR,
    input  logic                         IN_VALID,
    output logic                         IN_READY,
    input  logic [WIDTH-1:0]             D,
    output logic                         OUT_VALID,
    input  logic                         OUT_READY,
    output logic [WIDTH-1:0]             Q,
    output logic [$clog2(DEPTH+1)-1:0]   OCC
);
    localparam int OW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] data [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] adv;
    logic             xfer_in;
    logic             xfer_out;

    // A stage moves unless it and every stage downstream of it is full and the sink stalls.
    for (genvar s = 0; s < DEPTH; s++) begin : g_adv
        assign adv[s] = OUT_READY | ~&vld[DEPTH-1:s];
    end

    assign IN_READY  = RST & adv[0] & ~CLR;
    assign OUT_VALID = vld[DEPTH-1];
    assign Q         = data[DEPTH-1];
    assign xfer_in   = IN_VALID & IN_READY;
    assign xfer_out  = OUT_VALID & OUT_READY;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            vld <= '0;
            OCC <= '0;
            for (int i = 0; i < DEPTH; i++) data[i] <= RESET_VAL;
        end else if (CLR) begin
            vld <= '0;
            OCC <= '0;
        end else begin
            vld <= (adv & DEPTH'({vld, IN_VALID})) | (~adv & vld);
            OCC <= OCC + OW'(xfer_in) - OW'(xfer_out);
            if (adv[0]) data[0] <= D;
            for (int i = 1; i < DEPTH; i++) if (adv[i]) data[i] <= data[i-1];
        end
    end
endmodule

// File: tb/tb_pipe_reg.sv
// tb_pipe_reg: scoreboard bench for pipe_reg at DEPTH 2, 4 and 1 (1-bit).
module tb_pipe_reg;
    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;

    logic       clr2 = 0, iv2 = 0, or2 = 0, ir2, ov2;
    logic [7:0] d2 = 0, q2;
    logic [1:0] occ2;
    logic       clr4 = 0, iv4 = 0, or4 = 0, ir4, ov4;
    logic [7:0] d4 = 0, q4;
    logic [2:0] occ4;
    logic       clr1 = 0, iv1 = 0, or1 = 0, ir1, ov1, d1 = 0, q1;
    logic       occ1;

    pipe_reg #(.WIDTH(8), .DEPTH(2), .RESET_VAL(8'hA5)) u2 (
        .CLK(clk), .RST(rst), .CLR(clr2), .IN_VALID(iv2), .IN_READY(ir2), .D(d2),
        .OUT_VALID(ov2), .OUT_READY(or2), .Q(q2), .OCC(occ2));
    pipe_reg #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h3C)) u4 (
        .CLK(clk), .RST(rst), .CLR(clr4), .IN_VALID(iv4), .IN_READY(ir4), .D(d4),
        .OUT_VALID(ov4), .OUT_READY(or4), .Q(q4), .OCC(occ4));
    pipe_reg #(.WIDTH(1), .DEPTH(1), .RESET_VAL(1'b1)) u1 (
        .CLK(clk), .RST(rst), .CLR(clr1), .IN_VALID(iv1), .IN_READY(ir1), .D(d1),
        .OUT_VALID(ov1), .OUT_READY(or1), .Q(q1), .OCC(occ1));

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic spurious(input string name, input logic [63:0] act);
        n_vec++;
        n_err++;
        $display("FAIL %s: got word %0h expected no output at %0t", name, act, $time);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Scoreboards: accepted words are queued, emitted words popped and compared.
    logic [7:0] sb2[$], sb4[$];
    logic       sb1[$];
    logic       st2 = 0, st4 = 0, st1 = 0;
    logic [7:0] h2, h4;
    logic       h1;

    always @(negedge clk) begin
        if (st2 && rst) chk("u2_q_stable", {ov2, q2}, {1'b1, h2});
        st2 = rst && !clr2 && ov2 && !or2;
        h2 = q2;
        if (!rst) sb2.delete();
        else begin
            if (ov2 && or2) begin
                if (sb2.size() == 0) spurious("u2_spurious", q2);
                else chk("u2_data", q2, sb2.pop_front());
            end
            if (clr2) sb2.delete();
            else if (iv2 && ir2) sb2.push_back(d2);
        end
    end

    always @(negedge clk) begin
        if (st4 && rst) chk("u4_q_stable", {ov4, q4}, {1'b1, h4});
        st4 = rst && !clr4 && ov4 && !or4;
        h4 = q4;
        if (!rst) sb4.delete();
        else begin
            if (ov4 && or4) begin
                if (sb4.size() == 0) spurious("u4_spurious", q4);
                else chk("u4_data", q4, sb4.pop_front());
            end
            if (clr4) sb4.delete();
            else if (iv4 && ir4) sb4.push_back(d4);
        end
    end

    always @(negedge clk) begin
        if (st1 && rst) chk("u1_q_stable", {ov1, q1}, {1'b1, h1});
        st1 = rst && !clr1 && ov1 && !or1;
        h1 = q1;
        if (!rst) sb1.delete();
        else begin
            if (ov1 && or1) begin
                if (sb1.size() == 0) spurious("u1_spurious", q1);
                else chk("u1_data", q1, sb1.pop_front());
            end
            if (clr1) sb1.delete();
            else if (iv1 && ir1) sb1.push_back(d1);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [7:0] a_d   [6] = '{8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00};
    logic       a_ov  [6] = '{0, 0, 1, 1, 1, 0};
    logic [7:0] a_q   [6] = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
    logic [1:0] a_occ [6] = '{0, 1, 2, 2, 1, 0};
    logic [2:0] b_occ [8] = '{0, 1, 2, 3, 4, 4, 4, 4};
    logic       b_ir  [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
    logic [7:0] w [32];
    logic [4:0] pat = 5'b01101;
    int         sent;

    initial begin
        foreach (w[k]) w[k] = 8'($urandom);
        // Asynchronous reset from a quiet start
        #2 rst = 0;
        #1;
        chk("rst_u2_ov", ov2, 0);   chk("rst_u2_q", q2, 8'hA5);
        chk("rst_u2_occ", occ2, 0); chk("rst_u2_ir", ir2, 0);
        chk("rst_u4_ov", ov4, 0);   chk("rst_u4_q", q4, 8'h3C);
        chk("rst_u4_occ", occ4, 0); chk("rst_u4_ir", ir4, 0);
        chk("rst_u1_ov", ov1, 0);   chk("rst_u1_q", q1, 1);
        chk("rst_u1_occ", occ1, 0); chk("rst_u1_ir", ir1, 0);
        #9 rst = 1;

        // DEPTH=2 streaming, latency 2
        or2 = 1;
        for (int k = 0; k < 6; k++) begin
            tick;
            iv2 = k < 3;
            d2 = a_d[k];
            @(negedge clk);
            chk("a_ov", ov2, a_ov[k]);
            chk("a_occ", occ2, a_occ[k]);
            chk("a_ir", ir2, 1);
            if (a_ov[k]) chk("a_q", q2, a_q[k]);
        end

        // DEPTH=4 fill under backpressure, then release
        for (int k = 0; k < 8; k++) begin
            tick;
            iv4 = k < 6;
            d4 = 8'h41 + 8'(k);
            @(negedge clk);
            chk("b_ir", ir4, b_ir[k]);
            chk("b_occ", occ4, b_occ[k]);
            if (k == 4) chk("b_q_first", {ov4, q4}, {1'b1, 8'h41});
        end
        tick;
        or4 = 1;
        #1 chk("b_ir_release", ir4, 1);
        for (int c = 0; c < 20 && occ4 != 0; c++) @(negedge clk);
        tick;
        chk("b_drained_occ", occ4, 0);
        chk("b_drained_sb", sb4.size(), 0);

        // DEPTH=2, OUT_READY toggling with 32 random words
        sent = 0;
        for (int c = 0; c < 300 && sent < 32; c++) begin
            tick;
            or2 = (c % 2) == 0;
            iv2 = 1;
            d2 = w[sent];
            @(negedge clk);
            if (ir2) sent++;
        end
        tick;
        iv2 = 0;
        or2 = 1;
        for (int c = 0; c < 20 && occ2 != 0; c++) @(negedge clk);
        tick;
        chk("c_sent", sent, 32);
        chk("c_drained_sb", sb2.size(), 0);

        // Flush with three words held and a fourth offered
        or4 = 0;
        for (int k = 0; k < 3; k++) begin
            tick;
            iv4 = 1;
            d4 = 8'h51 + 8'(k);
        end
        tick;
        chk("d_occ_before", occ4, 3);
        clr4 = 1;
        d4 = 8'h54;
        #1 chk("d_ir_during_clr", ir4, 0);
        tick;
        clr4 = 0;
        iv4 = 0;
        chk("d_occ_after", occ4, 0);
        chk("d_ov_after", ov4, 0);
        or4 = 1;
        repeat (8) tick;
        chk("d_no_output", sb4.size(), 0);

        // Asynchronous reset between edges with two words in flight
        or2 = 0;
        tick; iv2 = 1; d2 = 8'h61;
        tick; d2 = 8'h62;
        tick; iv2 = 0;
        chk("e_occ_before", occ2, 2);
        #2 rst = 0;
        #1;
        chk("e_ov", ov2, 0);
        chk("e_q", q2, 8'hA5);
        chk("e_occ", occ2, 0);
        chk("e_ir", ir2, 0);
        tick;
        #2 rst = 1;
        or2 = 1;
        repeat (6) tick;
        chk("e_no_output", sb2.size(), 0);
        chk("e_occ_idle", occ2, 0);

        // DEPTH=1, WIDTH=1 passthrough
        or1 = 1;
        for (int k = 0; k < 7; k++) begin
            tick;
            iv1 = k < 5;
            d1 = (k < 5) ? pat[k] : 1'b0;
            @(negedge clk);
            chk("f_ir", ir1, 1);
            chk("f_ov", ov1, k >= 1 && k <= 5);
            if (k >= 1 && k <= 5) chk("f_q", q1, pat[k-1]);
        end
        or1 = 0;
        tick; iv1 = 1; d1 = 1;
        @(negedge clk);
        chk("f_ir_empty", ir1, 1);
        tick; d1 = 0;
        @(negedge clk);
        chk("f_ir_full", ir1, 0);
        chk("f_ov_full", ov1, 1);
        chk("f_occ_full", occ1, 1);
        tick; or1 = 1;
        #1 chk("f_ir_release", ir1, 1);
        tick; iv1 = 0;
        @(negedge clk);
        chk("f_q_last", {ov1, q1}, 2'b10);
        tick;
        @(negedge clk);
        chk("f_empty_ov", ov1, 0);
        chk("f_empty_occ", occ1, 0);

        tick;
        chk("end_sb2", sb2.size(), 0);
        chk("end_sb4", sb4.size(), 0);
        chk("end_sb1", sb1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
